// File: rtl/ucie_ctl_pkg.sv
// Shared constants for the UCIe controller receive path.
package ucie_ctl_pkg;
  localparam int CTL_DATA_W = 24;
  localparam int CTL_DEPTH  = 8;
  localparam int DROP_W     = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;
endpackage

// File: rtl/ucie_ctl_rx_fifo_mem.sv
// Receive FIFO storage: one write port, asynchronous read, no reset.
module ucie_ctl_rx_fifo_mem #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
)(
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/ucie_ctl_rx_fifo.sv
// RDI-to-FDI receive FIFO with registered head word, overflow tracking and flush.
module ucie_ctl_rx_fifo
  import ucie_ctl_pkg::*;
#(
  parameter int DATA_W   = CTL_DATA_W,
  parameter int DEPTH    = CTL_DEPTH,
  parameter int AFULL_TH = DEPTH - 2
)(
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [DATA_W-1:0]            i_rdi_pl_data,
  input  logic                         i_rdi_pl_valid,
  input  logic                         i_buffer_en,
  input  logic                         i_fdi_ready,
  input  logic                         i_flush,
  input  logic                         i_ovf_clr,
  output logic [DATA_W-1:0]            o_fdi_data,
  output logic                         o_fdi_data_valid,
  output logic [$clog2(DEPTH+2)-1:0]   o_count,
  output logic                         o_empty,
  output logic                         o_full,
  output logic                         o_almost_full,
  output logic                         o_overflow_detected,
  output logic [DROP_W-1:0]            o_drop_cnt
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+2);
  localparam logic [AW:0] AF_TH = (AW+1)'(AFULL_TH);

  logic [AW:0]       wptr, rptr, mem_cnt;
  logic [DATA_W-1:0] rd_data;
  logic              act, push, pop, drop;

  assign mem_cnt       = wptr - rptr;
  assign o_empty       = (wptr == rptr);
  assign o_full        = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign o_almost_full = (mem_cnt >= AF_TH);
  assign o_count       = CNT_W'(mem_cnt) + CNT_W'(o_fdi_data_valid);

  // A flush overrides any traffic in the same cycle, including drop accounting.
  assign act  = i_buffer_en && !i_flush;
  assign pop  = act && !o_empty && (!o_fdi_data_valid || i_fdi_ready);
  assign push = act && i_rdi_pl_valid && (!o_full || pop);
  assign drop = act && i_rdi_pl_valid && o_full && !pop;

  ucie_ctl_rx_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (i_clk),
    .we    (push),
    .waddr (wptr[AW-1:0]),
    .wdata (i_rdi_pl_data),
    .raddr (rptr[AW-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (i_flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Head register: refilled on pop, emptied on a handshake with nothing behind it.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_fdi_data       <= '0;
      o_fdi_data_valid <= 1'b0;
    end else if (i_flush) begin
      o_fdi_data_valid <= 1'b0;
    end else if (pop) begin
      o_fdi_data       <= rd_data;
      o_fdi_data_valid <= 1'b1;
    end else if (i_buffer_en && i_fdi_ready) begin
      o_fdi_data_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_overflow_detected <= 1'b0;
      o_drop_cnt          <= '0;
    end else if (i_ovf_clr) begin
      o_overflow_detected <= drop;
      o_drop_cnt          <= {{(DROP_W-1){1'b0}}, drop};
    end else if (drop) begin
      o_overflow_detected <= 1'b1;
      if (o_drop_cnt != DROP_MAX)
        o_drop_cnt <= o_drop_cnt + {{(DROP_W-1){1'b0}}, 1'b1};
    end
  end
endmodule

// File: tb/tb_ucie_ctl_rx_fifo.sv
// Directed vector bench for ucie_ctl_rx_fifo at DEPTH=8, DATA_W=24, AFULL_TH=6.
module tb_ucie_ctl_rx_fifo;
  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] din;
  logic        valid, en, ready, flush, clr;
  logic [23:0] dout;
  logic        dvld, empty, full, afull, ovf;
  logic [3:0]  cnt;
  logic [7:0]  drop;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  ucie_ctl_rx_fifo dut (
    .i_clk(clk), .i_rst(rst), .i_rdi_pl_data(din), .i_rdi_pl_valid(valid),
    .i_buffer_en(en), .i_fdi_ready(ready), .i_flush(flush), .i_ovf_clr(clr),
    .o_fdi_data(dout), .o_fdi_data_valid(dvld), .o_count(cnt), .o_empty(empty),
    .o_full(full), .o_almost_full(afull), .o_overflow_detected(ovf), .o_drop_cnt(drop)
  );

  typedef struct {
    logic        flush, clr, en, valid;
    logic [23:0] data;
    logic        ready;
    logic        evld;
    logic [23:0] edata;
    logic [3:0]  ecnt;
    logic        eempty, efull, eaf, eovf;
    logic [7:0]  edrop;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic f, c, e, v, input logic [23:0] d, input logic r,
                     input logic xv, input logic [23:0] xd, input int xc,
                     input logic xe, xf, xa, xo, input int xdr);
    vec_t t;
    t.flush = f; t.clr = c; t.en = e; t.valid = v; t.data = d; t.ready = r;
    t.evld = xv; t.edata = xd; t.ecnt = 4'(xc);
    t.eempty = xe; t.efull = xf; t.eaf = xa; t.eovf = xo; t.edrop = 8'(xdr);
    tbl.push_back(t);
  endtask

  // Drive one vector, clock it, then compare just after the edge.
  task automatic apply(input vec_t t, input string tag);
    flush = t.flush; clr = t.clr; en = t.en; valid = t.valid; din = t.data; ready = t.ready;
    @(posedge clk); #1;
    n_vec++;
    if (dvld !== t.evld || (t.evld && dout !== t.edata) || cnt !== t.ecnt ||
        empty !== t.eempty || full !== t.efull || afull !== t.eaf ||
        ovf !== t.eovf || drop !== t.edrop) begin
      n_miss++;
      $display("FAIL %s: got vld=%0b data=%h cnt=%0d e/f/af=%0b%0b%0b ovf=%0b drop=%0d, want vld=%0b data=%h cnt=%0d e/f/af=%0b%0b%0b ovf=%0b drop=%0d",
               tag, dvld, dout, cnt, empty, full, afull, ovf, drop,
               t.evld, t.edata, t.ecnt, t.eempty, t.efull, t.eaf, t.eovf, t.edrop);
    end
  endtask

  task automatic check_reset(input string tag);
    n_vec++;
    if (dvld !== 1'b0 || dout !== 24'h0 || cnt !== 4'd0 || empty !== 1'b1 ||
        full !== 1'b0 || afull !== 1'b0 || ovf !== 1'b0 || drop !== 8'd0) begin
      n_miss++;
      $display("FAIL %s: got vld=%0b data=%h cnt=%0d e/f/af=%0b%0b%0b ovf=%0b drop=%0d, want all zero with empty=1",
               tag, dvld, dout, cnt, empty, full, afull, ovf, drop);
    end
  endtask

  initial begin
    vec_t t;
    rst = 1'b0; din = '0; valid = 0; en = 1; ready = 0; flush = 0; clr = 0;

    // Three words straight through with the consumer always ready.
    add(0,0,1,1,24'hA,1, 0,24'h0,1, 0,0,0,0,0);
    add(0,0,1,1,24'hB,1, 1,24'hA,2, 0,0,0,0,0);
    add(0,0,1,1,24'hC,1, 1,24'hB,2, 0,0,0,0,0);
    add(0,0,1,0,24'h0,1, 1,24'hC,1, 1,0,0,0,0);
    add(0,0,1,0,24'h0,1, 0,24'h0,0, 1,0,0,0,0);
    // Fill under backpressure: 8 in memory plus the head word, then one drop.
    for (int k = 1; k <= 9; k++)
      add(0,0,1,1,24'(k),0, k>=2,24'h1,k, 0,k==9,k>=7,0,0);
    add(0,0,1,1,24'd10,0, 1,24'h1,9, 0,1,1,1,1);
    add(0,1,1,0,24'h0,0, 1,24'h1,9, 0,1,1,0,0);
    // Push and pop together while full; word 10 was dropped so the stream skips it.
    for (int j = 0; j < 12; j++)
      add(0,0,1,1,24'(11+j),1, 1,24'((2+j <= 9) ? 2+j : 3+j),9, 0,1,1,0,0);
    for (int d = 0; d < 8; d++)
      add(0,0,1,0,24'h0,1, 1,24'(15+d),8-d, d==7,0,d<=1,0,0);
    add(0,0,1,0,24'h0,1, 0,24'h0,0, 1,0,0,0,0);
    // Saturating drop counter.
    for (int k = 1; k <= 9; k++)
      add(0,0,1,1,24'(100+k),0, k>=2,24'd101,k, 0,k==9,k>=7,0,0);
    for (int n = 1; n <= 300; n++)
      add(0,0,1,1,24'h0,0, 1,24'd101,9, 0,1,1,1,(n > 255) ? 255 : n);
    add(0,1,1,0,24'h0,0, 1,24'd101,9, 0,1,1,0,0);
    add(0,1,1,1,24'h0,0, 1,24'd101,9, 0,1,1,1,1);
    // Flush ignores the concurrent push/pop and keeps the overflow state.
    add(1,0,1,1,24'h0,1, 0,24'h0,0, 1,0,0,1,1);
    for (int k = 1; k <= 5; k++)
      add(0,0,1,1,24'(200+k),0, k>=2,24'd201,k, 0,0,0,1,1);
    add(1,0,1,0,24'h0,0, 0,24'h0,0, 1,0,0,1,1);
    // Disabled block ignores valid, but clear still acts.
    add(0,0,0,1,24'h0,1, 0,24'h0,0, 1,0,0,1,1);
    add(0,1,0,0,24'h0,1, 0,24'h0,0, 1,0,0,0,0);
    add(0,0,1,1,24'h55,1, 0,24'h0,1, 0,0,0,0,0);
    add(0,0,1,0,24'h0,0, 1,24'h55,1, 1,0,0,0,0);
    add(0,0,0,0,24'h0,1, 1,24'h55,1, 1,0,0,0,0);
    add(0,0,1,0,24'h0,1, 0,24'h0,0, 1,0,0,0,0);

    #2 check_reset("reset_initial");
    @(posedge clk); #1 rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      apply(t, $sformatf("vec%0d", i));
    end

    // Asynchronous reset between edges while data is buffered.
    flush = 0; clr = 0; en = 1; ready = 0; valid = 1;
    for (int k = 0; k < 3; k++) begin
      din = 24'(24'h300 + k);
      @(posedge clk); #1;
    end
    valid = 0;
    #2 rst = 1'b0;
    #1 check_reset("reset_async_mid");
    @(posedge clk); #1 rst = 1'b1;
    check_reset("reset_hold");

    // First push after reset behaves as a push into an empty block.
    t = '{flush:0, clr:0, en:1, valid:1, data:24'h77, ready:1,
          evld:0, edata:24'h0, ecnt:4'd1, eempty:0, efull:0, eaf:0, eovf:0, edrop:8'd0};
    apply(t, "post_reset_push");
    t = '{flush:0, clr:0, en:1, valid:0, data:24'h0, ready:0,
          evld:1, edata:24'h77, ecnt:4'd1, eempty:1, efull:0, eaf:0, eovf:0, edrop:8'd0};
    apply(t, "post_reset_out");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
